// File: rtl/zclk_pkg.sv
// Shared definitions for the Z80 clock / turbo control slice.
//   - turbo speed codes driven onto the clock generator muxes
//   - turbo switch FSM state encoding
//   - counter widths and the stall arbiter reset grant
//   - rr_pick: round-robin choice between the two stall requesters
package zclk_pkg;

  localparam logic [1:0] TURBO_3M5 = 2'b00;
  localparam logic [1:0] TURBO_7M  = 2'b01;
  localparam logic [1:0] TURBO_14M = 2'b10;

  typedef enum logic [1:0] {
    T_IDLE   = 2'b00,
    T_ARMED  = 2'b01,
    T_SETTLE = 2'b10
  } turbo_st_e;

  localparam int SETTLE_W    = 4;
  localparam int STALL_CNT_W = 4;

  // Last grant out of reset points at bit 1, so bit 0 wins the first tie.
  localparam logic [1:0] GNT_RESET = 2'b10;

  // On a tie hand the stall to whoever did not own the previous one;
  // a single request is granted as-is (already one-hot).
  function automatic logic [1:0] rr_pick(input logic [1:0] req,
                                         input logic [1:0] last);
    return (req == 2'b11) ? ~last : req;
  endfunction

endpackage

// File: rtl/zstall_arb.sv
// Z80 clock stall arbiter.
// Starts a stall on a Z80 falling edge when any wait requester is active,
// holds it while the granted requester keeps its request up, and forces a
// release after STALL_MAX fclk cycles.
// Ports:
//   fclk      in   system clock
//   rst_n     in   asynchronous active-low reset
//   zneg      in   one-fclk pulse at each Z80 clock falling edge
//   wait_req  in   [1:0] stall requests (0: DRAM contention, 1: port wait)
//   zstall    out  stall active, freezes zpos/zneg generation
//   wait_gnt  out  [1:0] one-hot owner of the current stall, 0 when idle
//   stall_tmo out  sticky, set by any forced release
module zstall_arb
  import zclk_pkg::*;
#(
  parameter int STALL_MAX = 15
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       zneg,
  input  logic [1:0] wait_req,
  output logic       zstall,
  output logic [1:0] wait_gnt,
  output logic       stall_tmo
);

  localparam logic [STALL_CNT_W-1:0] STALL_LIM = STALL_CNT_W'(STALL_MAX);

  logic [STALL_CNT_W-1:0] stall_cnt, stall_cnt_d;
  logic [1:0]             last_gnt, last_gnt_d, gnt_d;
  logic                   zstall_d, tmo_d;
  logic                   hold;

  // Only the owner's request keeps the stall alive; the other bit is ignored.
  assign hold = |(wait_req & wait_gnt);

  always_comb begin
    zstall_d    = zstall;
    gnt_d       = wait_gnt;
    last_gnt_d  = last_gnt;
    tmo_d       = stall_tmo;
    stall_cnt_d = stall_cnt;
    if (zstall) begin
      if (!hold || stall_cnt >= STALL_LIM) begin
        zstall_d    = 1'b0;
        gnt_d       = 2'b00;
        last_gnt_d  = wait_gnt;
        stall_cnt_d = '0;
        if (hold) tmo_d = 1'b1;
      end else if (stall_cnt != '1) begin
        stall_cnt_d = stall_cnt + 1'b1;
      end
    end else if (zneg && wait_req != 2'b00) begin
      // stall_cnt tracks the number of cycles zstall has been high,
      // so it starts at 1 on the first stalled cycle.
      zstall_d    = 1'b1;
      gnt_d       = rr_pick(wait_req, last_gnt);
      stall_cnt_d = STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      zstall    <= 1'b0;
      wait_gnt  <= 2'b00;
      stall_tmo <= 1'b0;
      stall_cnt <= '0;
      last_gnt  <= GNT_RESET;
    end else begin
      zstall    <= zstall_d;
      wait_gnt  <= gnt_d;
      stall_tmo <= tmo_d;
      stall_cnt <= stall_cnt_d;
      last_gnt  <= last_gnt_d;
    end
  end

endmodule

// File: rtl/zturbo_ctrl.sv
// Z80 turbo speed switch controller with clock stall arbitration.
// A requested speed change is armed, then applied at the next falling edge
// of the refresh strobe (sampled on zpos), followed by a settle window of
// SETTLE_CYC zpos pulses during which new requests are ignored.
// Ports:
//   fclk      in   system clock
//   rst_n     in   asynchronous active-low reset
//   turbo_req in   [1:0] requested speed (00 3.5, 01 7, 1x 14 MHz)
//   rfsh_n    in   Z80 refresh strobe, sampled on zpos
//   zpos      in   one-fclk pulse at each Z80 clock rising edge
//   zneg      in   one-fclk pulse at each Z80 clock falling edge
//   wait_req  in   [1:0] stall requests (level)
//   int_turbo out  [1:0] applied speed to the clock generator
//   turbo_chg out  one-fclk pulse when int_turbo changes
//   zstall    out  freezes zpos/zneg generation
//   wait_gnt  out  [1:0] one-hot stall owner
//   stall_tmo out  sticky forced-release flag
module zturbo_ctrl
  import zclk_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int STALL_MAX  = 15
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic [1:0] turbo_req,
  input  logic       rfsh_n,
  input  logic       zpos,
  input  logic       zneg,
  input  logic [1:0] wait_req,
  output logic [1:0] int_turbo,
  output logic       turbo_chg,
  output logic       zstall,
  output logic [1:0] wait_gnt,
  output logic       stall_tmo
);

  turbo_st_e             st_q, st_d;
  logic [1:0]            req_q, turbo_d;
  logic                  old_rfsh_n, rfsh_fall, chg_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;

  assign rfsh_fall = zpos & old_rfsh_n & ~rfsh_n;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= T_IDLE;
      req_q      <= TURBO_3M5;
      old_rfsh_n <= 1'b1;
      settle_q   <= '0;
      int_turbo  <= TURBO_3M5;
      turbo_chg  <= 1'b0;
    end else begin
      st_q      <= st_d;
      req_q     <= turbo_req;
      settle_q  <= settle_d;
      int_turbo <= turbo_d;
      turbo_chg <= chg_d;
      if (zpos) old_rfsh_n <= rfsh_n;
    end
  end

  always_comb begin
    st_d     = st_q;
    turbo_d  = int_turbo;
    chg_d    = 1'b0;
    settle_d = settle_q;
    case (st_q)
      T_IDLE: begin
        if (req_q != int_turbo) st_d = T_ARMED;
      end
      T_ARMED: begin
        // A request that reverts to the applied speed cancels the switch,
        // even when a refresh fall lands in the same cycle.
        if (req_q == int_turbo) begin
          st_d = T_IDLE;
        end else if (rfsh_fall) begin
          turbo_d  = req_q;
          chg_d    = 1'b1;
          settle_d = SETTLE_W'(SETTLE_CYC);
          st_d     = T_SETTLE;
        end
      end
      T_SETTLE: begin
        if (zpos) begin
          if (settle_q <= SETTLE_W'(1)) begin
            settle_d = '0;
            st_d     = T_IDLE;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
      end
      default: st_d = T_IDLE;
    endcase
  end

  zstall_arb #(
    .STALL_MAX (STALL_MAX)
  ) u_arb (
    .fclk      (fclk),
    .rst_n     (rst_n),
    .zneg      (zneg),
    .wait_req  (wait_req),
    .zstall    (zstall),
    .wait_gnt  (wait_gnt),
    .stall_tmo (stall_tmo)
  );

endmodule

// File: tb/tb_zturbo_ctrl.sv
// Bench for zturbo_ctrl: directed scenarios followed by random stimulus,
// all cycles compared against a transaction-level reference model.
module tb_zturbo_ctrl;

  localparam int SETTLE_CYC = 2;
  localparam int STALL_MAX  = 15;

  logic       fclk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] turbo_req = 2'b00;
  logic       rfsh_n = 1'b1;
  logic       zpos = 1'b0;
  logic       zneg = 1'b0;
  logic [1:0] wait_req = 2'b00;
  logic [1:0] int_turbo;
  logic       turbo_chg;
  logic       zstall;
  logic [1:0] wait_gnt;
  logic       stall_tmo;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int m_speed, m_req, m_settle, m_owner, m_last, m_len;
  bit m_pending, m_old, m_chg, m_tmo;

  zturbo_ctrl #(
    .SETTLE_CYC (SETTLE_CYC),
    .STALL_MAX  (STALL_MAX)
  ) dut (
    .fclk      (fclk),
    .rst_n     (rst_n),
    .turbo_req (turbo_req),
    .rfsh_n    (rfsh_n),
    .zpos      (zpos),
    .zneg      (zneg),
    .wait_req  (wait_req),
    .int_turbo (int_turbo),
    .turbo_chg (turbo_chg),
    .zstall    (zstall),
    .wait_gnt  (wait_gnt),
    .stall_tmo (stall_tmo)
  );

  always #5 fclk = ~fclk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_speed = 0; m_req = 0; m_settle = 0; m_pending = 0; m_old = 1; m_chg = 0;
    m_owner = 0; m_last = 2; m_len = 0; m_tmo = 0;
  endtask

  // Advance the model by one fclk using the inputs currently driven.
  task automatic model_step();
    bit fall;
    fall  = zpos && m_old && !rfsh_n;
    m_chg = 0;
    if (m_settle > 0) begin
      if (zpos) m_settle--;
    end else if (m_pending) begin
      if (m_req == m_speed) m_pending = 0;
      else if (fall) begin
        m_speed = m_req; m_chg = 1; m_settle = SETTLE_CYC; m_pending = 0;
      end
    end else if (m_req != m_speed) begin
      m_pending = 1;
    end
    m_req = int'(turbo_req);
    if (zpos) m_old = rfsh_n;

    if (m_owner != 0) begin
      if (!wait_req[m_owner-1]) begin
        m_last = m_owner; m_owner = 0;
      end else if (m_len == STALL_MAX) begin
        m_last = m_owner; m_owner = 0; m_tmo = 1;
      end else begin
        m_len++;
      end
    end else if (zneg && wait_req != 2'b00) begin
      if (wait_req == 2'b11) m_owner = (m_last == 2) ? 1 : 2;
      else m_owner = wait_req[0] ? 1 : 2;
      m_len = 1;
    end
  endtask

  task automatic check_outs();
    logic [1:0] g;
    g = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    check("outs", {1'b0, int_turbo, turbo_chg, zstall, wait_gnt, stall_tmo},
          {1'b0, 2'(m_speed), m_chg, (m_owner != 0), g, m_tmo});
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic tick(input logic zp = 1'b0, input logic zn = 1'b0);
    zpos = zp; zneg = zn;
    model_step();
    @(posedge fclk); #1;
    check_outs();
    @(negedge fclk);
    zpos = 1'b0; zneg = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    turbo_req = 2'b00; rfsh_n = 1'b1; wait_req = 2'b00;
    @(negedge fclk);
    rst_n = 1'b1;
  endtask

  initial begin
    int hi;
    bit next_pos;
    logic zp, zn;

    // Reset state
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_int_turbo", 8'(int_turbo), 8'h00);
    check("rst_turbo_chg", 8'(turbo_chg), 8'h00);
    check("rst_zstall",    8'(zstall),    8'h00);
    check("rst_wait_gnt",  8'(wait_gnt),  8'h00);
    check("rst_stall_tmo", 8'(stall_tmo), 8'h00);
    repeat (2) @(negedge fclk);
    rst_n = 1'b1;

    // Turbo switch 00 -> 01 at a refresh fall
    turbo_req = 2'b01;
    tick(); tick(); tick();
    tick(1'b1, 1'b0);
    check("armed_no_change", 8'(int_turbo), 8'h00);
    rfsh_n = 1'b0;
    tick(1'b1, 1'b0);
    check("sw_int_turbo", 8'(int_turbo), 8'h01);
    check("sw_chg_pulse", 8'(turbo_chg), 8'h01);
    tick();
    check("sw_chg_single", 8'(turbo_chg), 8'h00);

    // Request 10 during settle is ignored until two zpos have passed
    turbo_req = 2'b10;
    tick(); tick();
    rfsh_n = 1'b1; tick(1'b1, 1'b0);
    rfsh_n = 1'b0; tick(1'b1, 1'b0);
    check("settle_ignore", 8'(int_turbo), 8'h01);
    tick();
    rfsh_n = 1'b1; tick(1'b1, 1'b0);
    rfsh_n = 1'b0; tick(1'b1, 1'b0);
    check("settle_then_sw", 8'(int_turbo), 8'h02);
    check("settle_then_chg", 8'(turbo_chg), 8'h01);
    rfsh_n = 1'b1; tick(1'b1, 1'b0); tick(1'b1, 1'b0);

    // Cancel: request leaves and returns before a refresh fall
    turbo_req = 2'b00; tick(); tick();
    turbo_req = 2'b10; tick(); tick();
    rfsh_n = 1'b0; tick(1'b1, 1'b0);
    check("cancel_int", 8'(int_turbo), 8'h02);
    check("cancel_chg", 8'(turbo_chg), 8'h00);

    // Cancel and refresh fall in the same cycle: cancel wins
    rfsh_n = 1'b1; tick(1'b1, 1'b0);
    turbo_req = 2'b01; tick(); tick();
    turbo_req = 2'b10; tick();
    rfsh_n = 1'b0; tick(1'b1, 1'b0);
    check("cancel_vs_fall_int", 8'(int_turbo), 8'h02);
    check("cancel_vs_fall_chg", 8'(turbo_chg), 8'h00);
    tick(); tick();

    // Tie twice: bit 0 first, then bit 1
    wait_req = 2'b11; tick(1'b0, 1'b1);
    check("tie1_gnt", 8'(wait_gnt), 8'h01);
    check("tie1_zstall", 8'(zstall), 8'h01);
    wait_req = 2'b10; tick();
    check("tie1_release", 8'(zstall), 8'h00);
    check("tie1_gnt_clear", 8'(wait_gnt), 8'h00);
    wait_req = 2'b11; tick(1'b0, 1'b1);
    check("tie2_gnt", 8'(wait_gnt), 8'h02);
    wait_req = 2'b00; tick(); tick();

    // Timeout: request held 20 cycles, stall lasts exactly STALL_MAX
    wait_req = 2'b01;
    hi = 0;
    tick(1'b0, 1'b1);
    if (zstall) hi++;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (zstall) hi++;
    end
    check("tmo_len", 8'(hi), 8'd15);
    check("tmo_flag", 8'(stall_tmo), 8'h01);
    wait_req = 2'b00; tick(); tick();
    check("tmo_sticky", 8'(stall_tmo), 8'h01);

    // Reset mid-stall with a switch armed
    turbo_req = 2'b01; wait_req = 2'b10;
    tick(1'b0, 1'b1); tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_zstall", 8'(zstall), 8'h00);
    check("rst_mid_chg", 8'(turbo_chg), 8'h00);
    check("rst_mid_tmo", 8'(stall_tmo), 8'h00);
    model_reset();
    turbo_req = 2'b00; rfsh_n = 1'b1; wait_req = 2'b00;
    @(negedge fclk);
    rst_n = 1'b1;

    // Random phase; Z80 edges alternate and stop while stalled
    next_pos = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(0, 15) == 0) turbo_req = 2'($urandom);
      if ($urandom_range(0, 3) == 0) rfsh_n = ~rfsh_n;
      if ($urandom_range(0, 7) == 0) wait_req = 2'($urandom);
      zp = 1'b0; zn = 1'b0;
      if (m_owner == 0 && $urandom_range(0, 1) == 1) begin
        if (next_pos) zp = 1'b1;
        else zn = 1'b1;
        next_pos = ~next_pos;
      end
      tick(zp, zn);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/zturbo_ctrl.md
ZTURBO_CTRL -- requirements
Module: zturbo_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2, number of zpos pulses after a turbo switch during which new requests are ignored.
REQ-002 Parameter STALL_MAX, default 15, maximum fclk cycles one stall may last before forced release.
REQ-003 fclk  in  1  system clock; all state on posedge fclk.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 turbo_req  in  2  requested speed: 2'b00 3.5 MHz, 2'b01 7 MHz, 2'b1x 14 MHz; may change on any fclk.
REQ-006 rfsh_n  in  1  Z80 refresh strobe (zclk domain, sampled only on zpos).
REQ-007 zpos  in  1  one-fclk pulse at each Z80 clock rising edge, from the clock generator.
REQ-008 zneg  in  1  one-fclk pulse at each Z80 clock falling edge, from the clock generator.
REQ-009 wait_req  in  2  stall requests; bit 0 DRAM contention, bit 1 port wait; level, held until serviced.
REQ-010 int_turbo  out  2  applied speed, drives the clock generator muxes.
REQ-011 turbo_chg  out  1  one-fclk pulse on the cycle int_turbo changes.
REQ-012 zstall  out  1  freezes zpos/zneg generation while high.
REQ-013 wait_gnt  out  2  one-hot grant, identifies the requester owning the current stall; 2'b00 when zstall low.
REQ-014 stall_tmo  out  1  sticky flag, set on any forced stall release.

Function
REQ-015 req_q registers turbo_req every fclk; all comparisons use req_q.
REQ-016 old_rfsh_n updates from rfsh_n only on zpos; rfsh_fall = zpos & old_rfsh_n & !rfsh_n.
REQ-017 Turbo FSM has three states: IDLE, ARMED, SETTLE.
REQ-018 IDLE: req_q != int_turbo -> ARMED next cycle.
REQ-019 ARMED: req_q == int_turbo -> IDLE, a cancel with no change; otherwise on rfsh_fall -> int_turbo <= req_q, turbo_chg = 1, settle_cnt <= SETTLE_CYC, -> SETTLE.
REQ-020 ARMED, cancel and rfsh_fall in the same cycle: the cancel wins, and int_turbo does not change.
REQ-021 SETTLE: settle_cnt decrements on each zpos; on a zpos with settle_cnt == 1 -> IDLE; req_q changes are ignored until IDLE.
REQ-022 int_turbo changes only on the ARMED->SETTLE transition; turbo_chg is never high for two consecutive cycles.
REQ-023 Stall start: a stall starts only on a zneg cycle while zstall == 0 and wait_req != 0; zstall and wait_gnt assert on the next fclk.
REQ-024 Stall arbitration: round-robin; on a double request, grant the requester not granted last; last_gnt resets to bit 1, so bit 0 wins the first tie.
REQ-025 Stall hold: zstall holds while the granted bit of wait_req is high; the other requester's bit is ignored during a stall.
REQ-026 Stall release: drop of the granted bit -> zstall and wait_gnt clear on the next fclk.
REQ-027 Stall timeout: stall_cnt (4 bits, saturating) counts fclk cycles with zstall high; at STALL_MAX, force release, set stall_tmo, update last_gnt.
REQ-028 Re-stall: after any release, a new stall requires a new zneg; no back-to-back stall without a zneg.
REQ-029 Independence: the turbo FSM runs independently of the stall logic; while zstall is high, no zpos arrives, so an ARMED switch waits.

Reset
REQ-030 On rst_n low, asynchronously: int_turbo = 2'b00, turbo_chg = 0, zstall = 0, wait_gnt = 2'b00, stall_tmo = 0.
REQ-031 On rst_n low, asynchronously: FSM = IDLE, req_q = 2'b00, old_rfsh_n = 1, settle_cnt = 0, stall_cnt = 0, last_gnt = 2'b10.
REQ-032 Reset mid-switch or mid-stall aborts it with no turbo_chg pulse.

Structure
REQ-033 The FSM state encoding and the turbo code constants (3.5/7/14) belong in the shared zclk package.
REQ-034 The stall arbiter is the one sub-module, zstall_arb; the turbo FSM stays inline.

Verification
REQ-035 Turbo switch: req 00->01, then rfsh_n falls sampled at zpos -> int_turbo = 01 one fclk after that zpos, with a single turbo_chg pulse.
REQ-036 Cancel: req 00->01->00 before any rfsh fall -> FSM returns to IDLE, turbo_chg stays 0, int_turbo stays 00.
REQ-037 Settle ignore: req 01->10 during SETTLE (SETTLE_CYC = 2) -> switch to 10 only at the first rfsh fall after two zpos.
REQ-038 Tie: wait_req = 11 at zneg twice in a row -> wait_gnt = 01, then 10 on the next stall.
REQ-039 Timeout: wait_req[0] held 20 cycles -> zstall high exactly 15 fclk, then stall_tmo = 1 sticky.
REQ-040 Reset mid-stall: rst_n low during a stall -> zstall = 0 immediately, with no turbo_chg pulse.
